// File: rtl/drr_pkg.sv
// Shared widths, FSM encoding and engine timing for the DRR rank path.
// drr_div_stage and drr_engine_v2 both take their default widths from here.
package drr_pkg;

    localparam int DRR_CLASS_WIDTH    = 5;
    localparam int DRR_WEIGHT_WIDTH   = 16;
    localparam int DRR_PKT_WIDTH      = 16;
    localparam int DRR_RESP_TIMEOUT   = 64;
    localparam int DRR_ENGINE_LATENCY = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_DIVIDE    = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_RESP = 3'd4
    } div_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drr_seq_divider.sv
// Restoring divider that produces one quotient bit per cycle.
// Latency is always DIVIDEND_WIDTH cycles after start, whatever the operands.
module drr_seq_divider
    import drr_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DRR_PKT_WIDTH,
    parameter int DIVISOR_WIDTH  = DRR_WEIGHT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      done,
    output logic [DIVISOR_WIDTH-1:0]  quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder
);

    localparam int            CW        = cnt_width(DIVIDEND_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DIVIDEND_WIDTH - 1);

    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
    logic [DIVISOR_WIDTH-1:0]  div_q, div_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      busy_q, busy_d;

    logic [DIVISOR_WIDTH:0]    partial;
    logic [DIVISOR_WIDTH-1:0]  rem_step;
    logic [DIVIDEND_WIDTH-1:0] quo_step;
    logic                      take;

    // The stored remainder stays below the divisor, so only the shifted partial needs the extra bit.
    always_comb begin
        partial  = {rem_q, quo_q[DIVIDEND_WIDTH-1]};
        take     = (partial >= {1'b0, div_q});
        rem_step = take ? (partial[DIVISOR_WIDTH-1:0] - div_q) : partial[DIVISOR_WIDTH-1:0];
        quo_step = {quo_q[DIVIDEND_WIDTH-2:0], take};
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            div_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Results are presented combinationally during the final step so the caller can register them.
    assign done      = busy_q && (cnt_q == LAST_STEP);
    assign remainder = rem_step;

    generate
        if (DIVIDEND_WIDTH > DIVISOR_WIDTH) begin : g_sat
            assign quotient = (|quo_step[DIVIDEND_WIDTH-1:DIVISOR_WIDTH]) ? '1
                                                                          : quo_step[DIVISOR_WIDTH-1:0];
        end else begin : g_ext
            assign quotient = DIVISOR_WIDTH'(quo_step);
        end
    endgenerate

endmodule

// File: rtl/drr_div_stage.sv
// DRR rank front end: per-class quantum lookup, sequential length/quantum divide,
// a single-cycle request to drr_engine_v2, then a wait for its response or a timeout.
module drr_div_stage
    import drr_pkg::*;
#(
    parameter int CLASS_WIDTH  = DRR_CLASS_WIDTH,
    parameter int WEIGHT_WIDTH = DRR_WEIGHT_WIDTH,
    parameter int PKT_WIDTH    = DRR_PKT_WIDTH,
    parameter int RESP_TIMEOUT = DRR_RESP_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [CLASS_WIDTH-1:0]  pkt_class_id,
    input  logic [PKT_WIDTH-1:0]    pkt_len,
    input  logic                    cfg_wr_en,
    input  logic [CLASS_WIDTH-1:0]  cfg_wr_class,
    input  logic [WEIGHT_WIDTH-1:0] cfg_wr_weight,
    output logic                    req_valid,
    output logic [CLASS_WIDTH-1:0]  req_class_id,
    output logic [WEIGHT_WIDTH-1:0] req_class_weight,
    output logic [WEIGHT_WIDTH-1:0] req_div_quotient,
    output logic [WEIGHT_WIDTH-1:0] req_div_remain,
    input  logic                    eng_resp_valid,
    output logic                    timeout_err
);

    localparam int                      DEPTH      = 2 ** CLASS_WIDTH;
    localparam int                      TW         = cnt_width(RESP_TIMEOUT);
    localparam logic [TW-1:0]           TMO_LAST   = TW'(RESP_TIMEOUT - 1);
    localparam logic [WEIGHT_WIDTH-1:0] WEIGHT_ONE = WEIGHT_WIDTH'(1);

    div_state_e state_q, state_d;

    logic [CLASS_WIDTH-1:0]  class_q, class_d;
    logic [PKT_WIDTH-1:0]    len_q, len_d;
    logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;
    logic [WEIGHT_WIDTH-1:0] weight_tbl_q [DEPTH];
    logic [WEIGHT_WIDTH-1:0] weight_tbl_d [DEPTH];
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;

    logic                    req_valid_q, req_valid_d;
    logic [CLASS_WIDTH-1:0]  req_class_id_q, req_class_id_d;
    logic [WEIGHT_WIDTH-1:0] req_class_weight_q, req_class_weight_d;
    logic [WEIGHT_WIDTH-1:0] req_div_quotient_q, req_div_quotient_d;
    logic [WEIGHT_WIDTH-1:0] req_div_remain_q, req_div_remain_d;
    logic                    timeout_err_q, timeout_err_d;

    logic                    div_start;
    logic                    div_done;
    logic [WEIGHT_WIDTH-1:0] div_quotient;
    logic [WEIGHT_WIDTH-1:0] div_remain;
    logic [WEIGHT_WIDTH-1:0] lookup_weight;
    logic                    tmo_hit;

    assign lookup_weight = weight_tbl_q[class_q];
    assign tmo_hit       = (tmo_cnt_q == TMO_LAST);

    drr_seq_divider #(
        .DIVIDEND_WIDTH (PKT_WIDTH),
        .DIVISOR_WIDTH  (WEIGHT_WIDTH)
    ) u_divider (
        .clk       (clk),
        .rstn      (rstn),
        .start     (div_start),
        .dividend  (len_q),
        .divisor   (lookup_weight),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remain)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (pkt_valid) state_d = ST_LOOKUP;
            ST_LOOKUP:    state_d = ST_DIVIDE;
            ST_DIVIDE:    if (div_done) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_WAIT_RESP;
            ST_WAIT_RESP: if (eng_resp_valid || tmo_hit) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pkt_ready = (state_q == ST_IDLE);
        div_start = (state_q == ST_LOOKUP);
    end

    // The divider reads the table in LOOKUP too, so divisor and frozen weight always agree.
    always_comb begin
        class_d            = class_q;
        len_d              = len_q;
        weight_d           = weight_q;
        weight_tbl_d       = weight_tbl_q;
        tmo_cnt_d          = '0;
        req_valid_d        = 1'b0;
        req_class_id_d     = req_class_id_q;
        req_class_weight_d = req_class_weight_q;
        req_div_quotient_d = req_div_quotient_q;
        req_div_remain_d   = req_div_remain_q;
        timeout_err_d      = 1'b0;

        if (cfg_wr_en) begin
            weight_tbl_d[cfg_wr_class] = (cfg_wr_weight == '0) ? WEIGHT_ONE : cfg_wr_weight;
        end

        case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    class_d = pkt_class_id;
                    len_d   = pkt_len;
                end
            end
            ST_LOOKUP: begin
                weight_d = lookup_weight;
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    req_valid_d        = 1'b1;
                    req_class_id_d     = class_q;
                    req_class_weight_d = weight_q;
                    req_div_quotient_d = div_quotient;
                    req_div_remain_d   = div_remain;
                end
            end
            ST_WAIT_RESP: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (!eng_resp_valid && tmo_hit) begin
                    timeout_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            class_q            <= '0;
            len_q              <= '0;
            weight_q           <= '0;
            tmo_cnt_q          <= '0;
            req_valid_q        <= 1'b0;
            req_class_id_q     <= '0;
            req_class_weight_q <= '0;
            req_div_quotient_q <= '0;
            req_div_remain_q   <= '0;
            timeout_err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                weight_tbl_q[i] <= WEIGHT_ONE;
            end
        end else begin
            class_q            <= class_d;
            len_q              <= len_d;
            weight_q           <= weight_d;
            tmo_cnt_q          <= tmo_cnt_d;
            req_valid_q        <= req_valid_d;
            req_class_id_q     <= req_class_id_d;
            req_class_weight_q <= req_class_weight_d;
            req_div_quotient_q <= req_div_quotient_d;
            req_div_remain_q   <= req_div_remain_d;
            timeout_err_q      <= timeout_err_d;
            weight_tbl_q       <= weight_tbl_d;
        end
    end

    assign req_valid        = req_valid_q;
    assign req_class_id     = req_class_id_q;
    assign req_class_weight = req_class_weight_q;
    assign req_div_quotient = req_div_quotient_q;
    assign req_div_remain   = req_div_remain_q;
    assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_drr_div_stage.sv
// Directed bench for drr_div_stage: a vector table of divide requests plus
// hand-written sequences for back-to-back issue, timeout, mid-divide writes and reset.
module tb_drr_div_stage;
    import drr_pkg::*;

    localparam int CW = 5;
    localparam int WW = 16;
    localparam int PW = 16;

    logic          clk;
    logic          rstn;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [CW-1:0] pkt_class_id;
    logic [PW-1:0] pkt_len;
    logic          cfg_wr_en;
    logic [CW-1:0] cfg_wr_class;
    logic [WW-1:0] cfg_wr_weight;
    logic          req_valid;
    logic [CW-1:0] req_class_id;
    logic [WW-1:0] req_class_weight;
    logic [WW-1:0] req_div_quotient;
    logic [WW-1:0] req_div_remain;
    logic          eng_resp_valid;
    logic          timeout_err;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [CW-1:0] cls;
        logic          doWrite;
        logic [WW-1:0] wrWeight;
        logic [PW-1:0] len;
        logic [WW-1:0] expWeight;
        logic [WW-1:0] expQuo;
        logic [WW-1:0] expRem;
    } vec_t;

    vec_t vecs [8];

    drr_div_stage #(
        .CLASS_WIDTH  (CW),
        .WEIGHT_WIDTH (WW),
        .PKT_WIDTH    (PW),
        .RESP_TIMEOUT (64)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_class_id     (pkt_class_id),
        .pkt_len          (pkt_len),
        .cfg_wr_en        (cfg_wr_en),
        .cfg_wr_class     (cfg_wr_class),
        .cfg_wr_weight    (cfg_wr_weight),
        .req_valid        (req_valid),
        .req_class_id     (req_class_id),
        .req_class_weight (req_class_weight),
        .req_div_quotient (req_div_quotient),
        .req_div_remain   (req_div_remain),
        .eng_resp_valid   (eng_resp_valid),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so a wedged DUT can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $display("%0d/%0d checks passed", passCount, checkCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cfgWrite(input logic [CW-1:0] cls, input logic [WW-1:0] w);
        cfg_wr_en     = 1'b1;
        cfg_wr_class  = cls;
        cfg_wr_weight = w;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; that cycle becomes C0. Returns the
    // cycle index of the req_valid pulse, or -1 if it never came.
    task automatic applyStimulus(input logic [CW-1:0] cls, input logic [PW-1:0] len,
                                 input int midWrCycle, input logic [WW-1:0] midWrWeight,
                                 output int lat);
        pkt_valid    = 1'b1;
        pkt_class_id = cls;
        pkt_len      = len;
        lat          = -1;
        for (int c = 0; c < 60; c++) begin
            if (c == midWrCycle) begin
                cfg_wr_en     = 1'b1;
                cfg_wr_class  = cls;
                cfg_wr_weight = midWrWeight;
            end
            @(negedge clk);
            pkt_valid = 1'b0;
            cfg_wr_en = 1'b0;
            if (req_valid) begin
                lat = c + 1;
                break;
            end
        end
    endtask

    // From the req_valid cycle, answer like drr_engine_v2 and confirm release one cycle later.
    task automatic engineRespond(input string tag);
        @(negedge clk);
        checkOutput({tag, " req_valid one cycle"}, req_valid, 0);
        repeat (DRR_ENGINE_LATENCY - 1) @(negedge clk);
        eng_resp_valid = 1'b1;
        checkOutput({tag, " ready low while waiting"}, pkt_ready, 0);
        @(negedge clk);
        eng_resp_valid = 1'b0;
        checkOutput({tag, " ready after response"}, pkt_ready, 1);
    endtask

    task automatic checkResult(input string tag, input int lat, input logic [CW-1:0] cls,
                               input logic [WW-1:0] w, input logic [WW-1:0] q,
                               input logic [WW-1:0] r);
        checkOutput({tag, " latency"}, lat, PW + 2);
        checkOutput({tag, " class"}, req_class_id, cls);
        checkOutput({tag, " weight"}, req_class_weight, w);
        checkOutput({tag, " quotient"}, req_div_quotient, q);
        checkOutput({tag, " remainder"}, req_div_remain, r);
    endtask

    initial begin
        int lat;
        int firstReq;
        int secondReq;
        int reqCount;
        int tOff;
        logic [WW-1:0] secondQuo;
        logic readyBefore;
        logic readyAt;

        vecs[0] = '{5'd3,  1'b1, 16'd4,      16'd10,     16'd4,      16'd2,    16'd2};
        vecs[1] = '{5'd7,  1'b1, 16'd0,      16'd7,      16'd1,      16'd7,    16'd0};
        vecs[2] = '{5'd5,  1'b1, 16'd1500,   16'd0,      16'd1500,   16'd0,    16'd0};
        vecs[3] = '{5'd9,  1'b1, 16'hFFFF,   16'hFFFF,   16'hFFFF,   16'd1,    16'd0};
        vecs[4] = '{5'd1,  1'b0, 16'd0,      16'd1234,   16'd1,      16'd1234, 16'd0};
        vecs[5] = '{5'd31, 1'b1, 16'd7,      16'd100,    16'd7,      16'd14,   16'd2};
        vecs[6] = '{5'd0,  1'b1, 16'd300,    16'd65535,  16'd300,    16'd218,  16'd135};
        vecs[7] = '{5'd4,  1'b1, 16'h8000,   16'hFFFF,   16'h8000,   16'd1,    16'h7FFF};

        rstn           = 1'b0;
        pkt_valid      = 1'b0;
        pkt_class_id   = '0;
        pkt_len        = '0;
        cfg_wr_en      = 1'b0;
        cfg_wr_class   = '0;
        cfg_wr_weight  = '0;
        eng_resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        checkOutput("reset pkt_ready", pkt_ready, 1);
        checkOutput("reset req_valid", req_valid, 0);
        checkOutput("reset timeout_err", timeout_err, 0);
        checkOutput("reset req_class_weight", req_class_weight, 0);
        checkOutput("reset req_div_quotient", req_div_quotient, 0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].doWrite) cfgWrite(vecs[i].cls, vecs[i].wrWeight);
            applyStimulus(vecs[i].cls, vecs[i].len, -1, '0, lat);
            checkResult($sformatf("vec%0d", i), lat, vecs[i].cls, vecs[i].expWeight,
                        vecs[i].expQuo, vecs[i].expRem);
            engineRespond($sformatf("vec%0d", i));
        end

        // Back-to-back: pkt_valid held high, second packet only taken at C22.
        firstReq  = -1;
        secondReq = -1;
        reqCount  = 0;
        secondQuo = '0;
        for (int c = 0; c < 46; c++) begin
            pkt_valid      = (c <= 22);
            pkt_class_id   = 5'd3;
            pkt_len        = (c < 22) ? 16'd10 : 16'd20;
            eng_resp_valid = (c == 21 || c == 43);
            if (c == 21) checkOutput("b2b ready at C21", pkt_ready, 0);
            if (c == 22) checkOutput("b2b ready at C22", pkt_ready, 1);
            if (req_valid) begin
                reqCount++;
                if (firstReq < 0) begin
                    firstReq = c;
                end else if (secondReq < 0) begin
                    secondReq = c;
                    secondQuo = req_div_quotient;
                end
            end
            @(negedge clk);
        end
        pkt_valid      = 1'b0;
        eng_resp_valid = 1'b0;
        checkOutput("b2b first req cycle", firstReq, 18);
        checkOutput("b2b second req cycle", secondReq, 40);
        checkOutput("b2b req count", reqCount, 2);
        checkOutput("b2b second quotient", secondQuo, 5);

        // Withheld response: timeout pulse 64 cycles after entering WAIT_RESP (C19).
        applyStimulus(5'd3, 16'd10, -1, '0, lat);
        checkOutput("tmo latency", lat, PW + 2);
        tOff        = -1;
        readyBefore = 1'bx;
        readyAt     = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 64) readyBefore = pkt_ready;
            if (timeout_err) begin
                tOff    = k;
                readyAt = pkt_ready;
                break;
            end
        end
        checkOutput("tmo pulse offset from req", tOff, 65);
        checkOutput("tmo ready before pulse", readyBefore, 0);
        checkOutput("tmo ready with pulse", readyAt, 1);
        @(negedge clk);
        checkOutput("tmo pulse width", timeout_err, 0);

        // Write to the in-flight class during DIVIDE: old weight used, new one next time.
        cfgWrite(5'd2, 16'd5);
        applyStimulus(5'd2, 16'd23, 4, 16'd7, lat);
        checkResult("midwr old", lat, 5'd2, 16'd5, 16'd4, 16'd3);
        engineRespond("midwr old");
        applyStimulus(5'd2, 16'd23, -1, '0, lat);
        checkResult("midwr new", lat, 5'd2, 16'd7, 16'd3, 16'd2);
        engineRespond("midwr new");

        // Reset mid-DIVIDE: nothing issued, outputs cleared, table back to 1.
        cfgWrite(5'd6, 16'd9);
        pkt_valid    = 1'b1;
        pkt_class_id = 5'd6;
        pkt_len      = 16'd50;
        @(negedge clk);
        pkt_valid = 1'b0;
        repeat (8) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("rst pkt_ready", pkt_ready, 1);
        checkOutput("rst req_valid", req_valid, 0);
        checkOutput("rst req_class_id", req_class_id, 0);
        checkOutput("rst req_class_weight", req_class_weight, 0);
        checkOutput("rst req_div_remain", req_div_remain, 0);
        @(negedge clk);
        rstn     = 1'b1;
        reqCount = 0;
        repeat (30) begin
            @(negedge clk);
            if (req_valid) reqCount++;
        end
        checkOutput("rst no pulse after abort", reqCount, 0);
        applyStimulus(5'd6, 16'd50, -1, '0, lat);
        checkResult("rst next", lat, 5'd6, 16'd1, 16'd50, 16'd0);
        engineRespond("rst next");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/drr_div_stage.md
# drr_div_stage

Per-packet front end of the DRR rank calculator. Accepts a (class, packet length) request, looks up the class quantum in a local weight table, and divides the length by the quantum in a sequential restoring divider. It issues the quotient and remainder as a single-cycle request to `drr_engine_v2`, then holds off new work until the engine returns its rank, because the engine has no ready signal.

## Interface
- `CLASS_WIDTH`, 5: class id width; table depth is 2**CLASS_WIDTH.
- `WEIGHT_WIDTH`, 16: quantum, quotient and remainder width.
- `PKT_WIDTH`, 16: packet length width.
- `RESP_TIMEOUT`, 64: maximum cycles to wait for the engine response.
- `clk`  in  1  the block's single clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `pkt_valid`  in  1  request present.
- `pkt_ready`  out  1  block can accept; high only in IDLE.
- `pkt_class_id`  in  CLASS_WIDTH  class of the request.
- `pkt_len`  in  PKT_WIDTH  packet length in bytes.
- `cfg_wr_en`  in  1  weight-table write strobe.
- `cfg_wr_class`  in  CLASS_WIDTH  entry to write.
- `cfg_wr_weight`  in  WEIGHT_WIDTH  new quantum; 0 is stored as 1.
- `req_valid`  out  1  one-cycle pulse to the engine.
- `req_class_id`  out  CLASS_WIDTH  class id presented to the engine.
- `req_class_weight`  out  WEIGHT_WIDTH  class quantum presented to the engine.
- `req_div_quotient`  out  WEIGHT_WIDTH  `pkt_len / weight`.
- `req_div_remain`  out  WEIGHT_WIDTH  `pkt_len % weight`.
- `eng_resp_valid`  in  1  engine `resp_valid`; releases the block.
- `timeout_err`  out  1  one-cycle pulse when the engine response does not arrive.

## Operation
- FSM: IDLE → LOOKUP → DIVIDE → ISSUE → WAIT_RESP → IDLE.
- **IDLE**
  - `pkt_ready`=1.
  - On `pkt_valid`, latch class and length, then go to LOOKUP.
- **LOOKUP**
  - Latch `weight[class]`.
  - Writes already committed at earlier edges are visible; a write in the same cycle is not.
- **DIVIDE**
  - Restoring division, one quotient bit per cycle, always exactly PKT_WIDTH cycles regardless of operand values.
  - Partial remainder is WEIGHT_WIDTH+1 bits wide.
  - If PKT_WIDTH > WEIGHT_WIDTH and the quotient does not fit, the quotient saturates to all ones.
  - The remainder is always less than the weight.
- **ISSUE**
  - `req_valid`=1 for exactly one cycle.
  - `req_*` hold their values from ISSUE until the next ISSUE.
- **WAIT_RESP**
  - On `eng_resp_valid`, go to IDLE.
  - A timeout counter starts at 0 on entry. When it reaches RESP_TIMEOUT-1 without a response, pulse `timeout_err` and go to IDLE.
  - `eng_resp_valid` outside WAIT_RESP is ignored.
- **Weight table**
  - Reset value is 1 in every entry.
  - A write to 0 is clamped to 1, so the divisor is never zero.
  - Writes are accepted in every state.
  - The weight used by an in-flight packet is frozen at LOOKUP.
- **Reset**
  - Reset at any point, including mid-DIVIDE, aborts the operation with no output pulse.
  - Reset state: FSM IDLE, `pkt_ready`=1, table entries all 1, all other outputs 0.

## Timing
- Let C0 be the cycle in which `pkt_valid && pkt_ready`.
- C1 is LOOKUP.
- C2 to C(PKT_WIDTH+1) is DIVIDE (C2–C17 at the default width).
- `req_valid` is high in C(PKT_WIDTH+2), which is C18 at the default width.
- `drr_engine_v2` returns `resp_valid` 3 cycles after `req_valid` (C21). The block is in IDLE in C22, so the minimum issue-to-issue period is PKT_WIDTH+6 cycles.
- `pkt_ready` is 0 from C1 until the cycle after the response.

## Structure
- Package `drr_pkg` holds:
  - width localparams and defaults shared with `drr_engine_v2`;
  - FSM state encodings (3-bit);
  - the `DRR_ENGINE_LATENCY=3` constant.
- Sub-module `drr_seq_divider` takes start/dividend/divisor and returns done/quotient/remainder, with fixed PKT_WIDTH-cycle latency.
- The weight table is flop-based inside the top module: `2**CLASS_WIDTH` × WEIGHT_WIDTH.

## Test plan
- Class 3, weight 4, `pkt_len`=10 → `req_valid` at C18 with class 3, weight 4, quotient 2, remainder 2.
- Write weight 0 to class 7, then `pkt_len`=7 → weight 1, quotient 7, remainder 0.
- Weight 1500, `pkt_len`=0 → quotient 0, remainder 0, still issued at C18.
- Two back-to-back `pkt_valid`, engine responding 3 cycles after each pulse → second request accepted only at C22, second `req_valid` at C40.
- Engine response withheld → `timeout_err` pulse RESP_TIMEOUT cycles after entering WAIT_RESP, then `pkt_ready`=1.
- `rstn` low during DIVIDE → no `req_valid`, all outputs 0, weights back to 1; the next request works normally.
- Write to class 2 while class 2 is in DIVIDE → the in-flight result uses the old weight; the next request uses the new weight.
